// File: rtl/timer_counter_pkg.sv
// Shared definitions for the bridge-mapped countdown timer.
// Holds the FSM state encoding, the register offsets and the CTRL field layout.
package timer_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // Only code 1 reloads; codes 2 and 3 fall back to one-shot behaviour.
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD);
  endfunction

  function automatic logic [31:0] ctrl_word(input logic en, input logic [1:0] mode, input logic im);
    logic [31:0] w;
    w = 32'd0;
    w[CTRL_EN] = en;
    w[CTRL_MODE_HI:CTRL_MODE_LO] = mode;
    w[CTRL_IM] = im;
    return w;
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Bridge-side bus of the timer: word offset, write strobe/data, read data and interrupt.
interface timer_counter_if;

  logic [3:2]  Addr;
  logic        WE;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        IRQ;

  modport master (
    output Addr,
    output WE,
    output WData,
    input  RData,
    input  IRQ
  );

  modport slave (
    input  Addr,
    input  WE,
    input  WData,
    output RData,
    output IRQ
  );

endinterface

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with one-shot (level IRQ) and auto-reload
// (single-cycle IRQ pulse) modes; IRQ feeds the CPU's HWInt[2].
module timer_counter
  import timer_defs::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  timer_counter_if.slave bus
);

  state_e      state_r;
  state_e      next_state_s;
  logic        en_r;
  logic [1:0]  mode_r;
  logic        im_r;
  logic [31:0] preset_r;
  logic [31:0] count_r;
  logic        irq_flag_r;

  logic        wr_ctrl_s;
  logic        wr_preset_s;
  logic        count_le1_s;
  logic        load_s;
  logic        dec_s;
  logic        hit_s;
  logic        clr_en_s;
  logic        drop_flag_s;
  logic [31:0] rdata_s;

  assign wr_ctrl_s   = bus.WE && (bus.Addr == OFF_CTRL);
  assign wr_preset_s = bus.WE && (bus.Addr == OFF_PRESET);
  assign count_le1_s = (count_r <= 32'd1);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state decision; a zero PRESET skips CNT so INT lands on the load edge + 1
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en_r) next_state_s = ST_LOAD;
        else      next_state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (preset_r == 32'd0) next_state_s = ST_INT;
        else                   next_state_s = ST_CNT;
      end
      ST_CNT: begin
        if (!en_r)            next_state_s = ST_IDLE;
        else if (count_le1_s) next_state_s = ST_INT;
        else                  next_state_s = ST_CNT;
      end
      ST_INT:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: per-state datapath controls
  always_comb begin
    load_s      = 1'b0;
    dec_s       = 1'b0;
    hit_s       = 1'b0;
    clr_en_s    = 1'b0;
    drop_flag_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
      end
      ST_LOAD: begin
        load_s = 1'b1;
        hit_s  = (preset_r == 32'd0);
      end
      ST_CNT: begin
        if (en_r) begin
          dec_s = !count_le1_s;
          hit_s = count_le1_s;
        end else begin
          dec_s = 1'b0;
          hit_s = 1'b0;
        end
      end
      ST_INT: begin
        clr_en_s    = !is_reload(mode_r);
        drop_flag_s = is_reload(mode_r);
      end
      default: begin
      end
    endcase
  end

  // CTRL register; a bus write beats the one-shot En clear in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_r   <= 1'b0;
      mode_r <= MODE_ONESHOT;
      im_r   <= 1'b0;
    end else if (wr_ctrl_s) begin
      en_r   <= bus.WData[CTRL_EN];
      mode_r <= bus.WData[CTRL_MODE_HI:CTRL_MODE_LO];
      im_r   <= bus.WData[CTRL_IM];
    end else if (clr_en_s) begin
      en_r   <= 1'b0;
    end
  end

  // PRESET register; only sampled into COUNT in LOAD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      preset_r <= PRESET_RST;
    end else if (wr_preset_s) begin
      preset_r <= bus.WData;
    end
  end

  // COUNT register: load, saturate to zero on expiry, otherwise decrement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= 32'd0;
    end else if (load_s) begin
      count_r <= preset_r;
    end else if (hit_s) begin
      count_r <= 32'd0;
    end else if (dec_s) begin
      count_r <= count_r - 32'd1;
    end
  end

  // Interrupt flag: expiry sets it and takes priority over any clearing source
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_flag_r <= 1'b0;
    end else if (hit_s) begin
      irq_flag_r <= 1'b1;
    end else if (wr_ctrl_s || wr_preset_s || drop_flag_s) begin
      irq_flag_r <= 1'b0;
    end
  end

  // Combinational read-back of the addressed register
  always_comb begin
    rdata_s = 32'd0;
    case (bus.Addr)
      OFF_CTRL:   rdata_s = ctrl_word(en_r, mode_r, im_r);
      OFF_PRESET: rdata_s = preset_r;
      OFF_COUNT:  rdata_s = count_r;
      OFF_RSVD:   rdata_s = 32'd0;
      default:    rdata_s = 32'd0;
    endcase
  end

  assign bus.RData = rdata_s;
  assign bus.IRQ   = im_r & irq_flag_r;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed timeline checks plus a
// randomized bus phase compared every cycle against a behavioural model.
module tb_timer_counter;

  localparam logic [31:0] P_RST = 32'hA5A5_0003;
  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_CNT  = 2;
  localparam int PH_INT  = 3;

  logic clk;
  logic reset;
  timer_counter_if bus();

  timer_counter #(.PRESET_RST(P_RST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  logic chk_on;

  // Behavioural model state
  logic        m_en;
  logic [1:0]  m_mode;
  logic        m_im;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  int          m_phase;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] n_count;
    logic        n_en;
    int          n_phase;
    logic        fire;
    logic        leave_reload;
    logic        wc;
    logic        wp;
    if (reset) begin
      m_en = 1'b0; m_mode = 2'd0; m_im = 1'b0; m_preset = P_RST;
      m_count = 32'd0; m_flag = 1'b0; m_phase = PH_IDLE;
      return;
    end
    n_count = m_count; n_en = m_en; n_phase = m_phase;
    fire = 1'b0; leave_reload = 1'b0;
    case (m_phase)
      PH_IDLE: if (m_en) n_phase = PH_LOAD;
      PH_LOAD: begin
        n_count = m_preset;
        if (m_preset == 32'd0) begin fire = 1'b1; n_phase = PH_INT; end
        else n_phase = PH_CNT;
      end
      PH_CNT: begin
        if (!m_en) n_phase = PH_IDLE;
        else if (m_count > 32'd1) n_count = m_count - 32'd1;
        else begin n_count = 32'd0; fire = 1'b1; n_phase = PH_INT; end
      end
      default: begin
        n_phase = PH_IDLE;
        if (m_mode == 2'd1) leave_reload = 1'b1;
        else n_en = 1'b0;
      end
    endcase
    wc = bus.WE && (bus.Addr == 2'd0);
    wp = bus.WE && (bus.Addr == 2'd1);
    if (wc) begin
      n_en = bus.WData[0]; m_mode = bus.WData[2:1]; m_im = bus.WData[3];
    end
    if (wp) m_preset = bus.WData;
    if (fire) m_flag = 1'b1;
    else if (wc || wp || leave_reload) m_flag = 1'b0;
    m_en = n_en; m_count = n_count; m_phase = n_phase;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      model_step();
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (chk_on) begin
        check("rdata", bus.RData, m_rd(bus.Addr));
        check("irq", {31'd0, bus.IRQ}, {31'd0, m_im & m_flag});
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = a; bus.WE = 1'b1; bus.WData = d;
    @(negedge clk);
    bus.WE = 1'b0; bus.Addr = 2'd2;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.Addr = a;
    #2;
    check(name, bus.RData, exp);
  endtask

  task automatic irq_check(input string name, input logic exp);
    #2;
    check(name, {31'd0, bus.IRQ}, {31'd0, exp});
  endtask

  int first_hi;
  int n_hi;
  int n_rise;
  logic prev_irq;

  initial begin
    n_tests = 0; n_fail = 0; chk_on = 1'b0;
    reset = 1'b0; bus.WE = 1'b0; bus.Addr = 2'd0; bus.WData = 32'd0;

    // Asynchronous reset between clock edges
    #12;
    reset = 1'b1;
    #1; check("rst_irq", {31'd0, bus.IRQ}, 32'd0);
    bus.Addr = 2'd0; #1; check("rst_ctrl", bus.RData, 32'd0);
    bus.Addr = 2'd1; #1; check("rst_preset", bus.RData, P_RST);
    bus.Addr = 2'd2; #1; check("rst_count", bus.RData, 32'd0);
    bus.Addr = 2'd3; #1; check("rst_rsvd", bus.RData, 32'd0);
    @(negedge clk);
    reset = 1'b0; chk_on = 1'b1;
    idle(2);

    // One-shot, N=5
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    idle(2);
    for (int i = 0; i < 5; i++) begin
      rd_check("os_count", 2'd2, 32'd5 - 32'(i));
      @(negedge clk);
    end
    irq_check("os_irq_e7", 1'b1);
    rd_check("os_ctrl_e7", 2'd0, 32'h9);
    @(negedge clk);
    rd_check("os_ctrl_e8", 2'd0, 32'h8);
    idle(3);
    irq_check("os_irq_hold", 1'b1);
    wr(2'd1, 32'd5);
    irq_check("os_irq_clr", 1'b0);

    // Auto-reload, N=3: one-cycle pulse every 6 cycles
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    first_hi = -1; n_hi = 0; n_rise = 0; prev_irq = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      #2;
      if (bus.IRQ) begin
        n_hi++;
        if (first_hi < 0) first_hi = i;
        if (!prev_irq) n_rise++;
      end
      prev_irq = bus.IRQ;
    end
    check("ar_first", 32'(first_hi), 32'd5);
    check("ar_high_cycles", 32'(n_hi), 32'd4);
    check("ar_pulses", 32'(n_rise), 32'd4);
    wr(2'd0, 32'h3);
    n_hi = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      #2;
      if (bus.IRQ) n_hi++;
    end
    check("ar_masked", 32'(n_hi), 32'd0);
    wr(2'd0, 32'h0);
    idle(4);

    // Disable mid-count, then re-enable
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);
    idle(42);
    rd_check("dis_count60", 2'd2, 32'd60);
    wr(2'd0, 32'h8);
    rd_check("dis_count59", 2'd2, 32'd59);
    idle(5);
    rd_check("dis_frozen", 2'd2, 32'd59);
    irq_check("dis_no_irq", 1'b0);
    wr(2'd0, 32'h9);
    rd_check("re_e0", 2'd2, 32'd59);
    @(negedge clk);
    rd_check("re_e1", 2'd2, 32'd59);
    @(negedge clk);
    rd_check("re_e2", 2'd2, 32'd100);
    wr(2'd0, 32'h8);
    idle(2);
    rd_check("dis2_frozen", 2'd2, 32'd99);

    // Ignored writes
    wr(2'd2, 32'h1234);
    rd_check("count_ro", 2'd2, 32'd99);
    wr(2'd3, 32'hFFFF_FFFF);
    rd_check("rsvd_ro", 2'd3, 32'd0);

    // PRESET=0 one-shot
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    irq_check("z_irq_e0", 1'b0);
    @(negedge clk);
    irq_check("z_irq_e1", 1'b0);
    @(negedge clk);
    irq_check("z_irq_e2", 1'b1);
    rd_check("z_count_e2", 2'd2, 32'd0);
    @(negedge clk);
    rd_check("z_ctrl_e3", 2'd0, 32'h8);

    // CTRL write in the INT cycle of mode 0
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    idle(4);
    irq_check("col_int", 1'b1);
    wr(2'd0, 32'h9);
    rd_check("col_ctrl", 2'd0, 32'h9);
    irq_check("col_irq_clr", 1'b0);
    idle(2);
    rd_check("col_count", 2'd2, 32'd2);
    idle(2);
    irq_check("col_irq_again", 1'b1);
    wr(2'd0, 32'h0);
    idle(4);

    // Reset in the middle of a count
    wr(2'd1, 32'd50);
    wr(2'd0, 32'h9);
    idle(10);
    #3;
    reset = 1'b1;
    #1;
    bus.Addr = 2'd2;
    #1; check("mid_rst_count", bus.RData, 32'd0);
    check("mid_rst_irq", {31'd0, bus.IRQ}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // Randomized bus traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.Addr = 2'($urandom_range(0, 3));
      bus.WE   = ($urandom_range(0, 7) == 0);
      if (bus.Addr == 2'd1) bus.WData = 32'($urandom_range(0, 9));
      else                  bus.WData = $urandom;
    end
    @(negedge clk);
    bus.WE = 1'b0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
